// File: rtl/iomem_pkg.sv
// Shared state encoding, bus widths and default abort data for the iomem arbiter.
package iomem_pkg;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;
endpackage

// File: rtl/iomem_rr_pick.sv
// Two-way round-robin choice: a lone requester always wins, a tie goes to the pointer.
module iomem_rr_pick (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] pick
);
   always_comb begin
      pick = '0;
      if (valid[0] && valid[1])
         pick = ptr ? 2'b10 : 2'b01;
      else if (valid[0])
         pick = 2'b01;
      else if (valid[1])
         pick = 2'b10;
   end
endmodule

// File: rtl/iomem_arbiter.sv
// Arbitrates two picorv32-style memory requesters onto one shared iomem port,
// with round-robin fairness and a bounded wait for the target's s_ready.
module iomem_arbiter
   import iomem_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              s_valid,
   input  logic              s_ready,
   output logic [STRB_W-1:0] s_wstrb,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic [DATA_W-1:0] s_rdata,
   output logic              timeout_err,
   output logic [1:0]        grant
);
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        rr_ptr;
   logic [15:0] tmo_cnt;
   logic [1:0]  pick;

   iomem_rr_pick u_pick (
      .valid ({m1_valid, m0_valid}),
      .ptr   (rr_ptr),
      .pick  (pick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         rr_ptr      <= 1'b0;
         tmo_cnt     <= '0;
         grant       <= '0;
         s_valid     <= 1'b0;
         s_wstrb     <= '0;
         s_addr      <= '0;
         s_wdata     <= '0;
         m0_ready    <= 1'b0;
         m1_ready    <= 1'b0;
         m0_rdata    <= '0;
         m1_rdata    <= '0;
         timeout_err <= 1'b0;
      end else begin
         m0_ready    <= 1'b0;
         m1_ready    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|pick) begin
                  grant   <= pick;
                  s_wstrb <= pick[1] ? m1_wstrb : m0_wstrb;
                  s_addr  <= pick[1] ? m1_addr  : m0_addr;
                  s_wdata <= pick[1] ? m1_wdata : m0_wdata;
                  s_valid <= 1'b1;
                  tmo_cnt <= '0;
                  state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               // Abort on the cycle the wait count would reach TIMEOUT_CYCLES; s_ready still wins that cycle.
               if (s_ready || tmo_cnt == CNT_LAST) begin
                  if (grant[0]) m0_rdata <= s_ready ? s_rdata : ERR_RDATA;
                  if (grant[1]) m1_rdata <= s_ready ? s_rdata : ERR_RDATA;
                  m0_ready    <= grant[0];
                  m1_ready    <= grant[1];
                  timeout_err <= ~s_ready;
                  rr_ptr      <= grant[0];
                  s_valid     <= 1'b0;
                  state       <= ST_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            ST_RESP: begin
               grant <= '0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: REQ-state cycles without s_ready before abort (range 1..65535).
REQ-002 Parameter ERR_RDATA, default 32'hFFFF_FFFF: read data returned on timeout.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 m0_valid/m1_valid  input  1  requester N transaction request (picorv32 mem-style; held until ready).
REQ-006 m0_ready/m1_ready  output  1  requester N completion, one-cycle pulse.
REQ-007 m0_wstrb/m1_wstrb  input  4  byte write strobes; 0 = read.
REQ-008 m0_addr/m1_addr, m0_wdata/m1_wdata  input  32  address, write data.
REQ-009 m0_rdata/m1_rdata  output  32  read data, valid while mN_ready=1.
REQ-010 s_valid  output  1  shared iomem request.
REQ-011 s_ready  input  1  shared iomem completion.
REQ-012 s_wstrb  output 4, s_addr  output 32, s_wdata  output 32: registered copy of granted request.
REQ-013 s_rdata  input  32  shared iomem read data, sampled when s_ready=1.
REQ-014 timeout_err  output  1  one-cycle pulse on aborted transaction.
REQ-015 grant  output  2  one-hot current owner (01=m0, 10=m1, 00=none).

Function
REQ-016 FSM SHALL have states IDLE, REQ, RESP.
REQ-017 IDLE: if any mN_valid, SHALL latch winner's wstrb/addr/wdata into s_* registers, set grant, go REQ next edge.
REQ-018 Simultaneous m0_valid and m1_valid SHALL grant the requester not served last (round-robin pointer); pointer after reset favours m0.
REQ-019 Pointer SHALL update only on completion (normal or timeout), to the other requester.
REQ-020 REQ: s_valid=1; request latency from mN_valid in IDLE to s_valid=1 is exactly 1 cycle.
REQ-021 REQ with s_ready=1: SHALL capture s_rdata into owner's rdata register, drop s_valid, go RESP.
REQ-022 RESP (exactly 1 cycle): owner mN_ready=1, other mN_ready=0; no arbitration; next state IDLE, grant=00.
REQ-023 s_ready outside REQ SHALL be ignored.
REQ-024 Timeout counter SHALL clear on REQ entry and increment each REQ cycle without s_ready; on reaching TIMEOUT_CYCLES SHALL drop s_valid, load ERR_RDATA into owner's rdata, go RESP, pulse timeout_err with mN_ready.
REQ-025 s_ready in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal completion, no timeout_err.
REQ-026 Non-owner valid SHALL be held pending (no ready) until arbitrated; request signals of non-owner SHALL not affect s_*.
REQ-027 s_* and mN_rdata SHALL hold value between transactions.
REQ-028 Maximum throughput: one transaction per 3 cycles with s_ready in first REQ cycle.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, s_valid=0, m0_ready=m1_ready=0, timeout_err=0, grant=00, pointer=m0, counter=0, s_wstrb=0, s_addr=0, s_wdata=0, mN_rdata=0.
REQ-030 Reset mid-REQ SHALL abandon the transaction without a ready pulse; requester reissues.

Structure
REQ-031 Package iomem_pkg SHALL hold the state enum, bus width constants (ADDR_W=32, DATA_W=32, STRB_W=4) and default ERR_RDATA.
REQ-032 One sub-module iomem_rr_pick SHALL implement the 2-way round-robin choice (inputs: valids, pointer; output: one-hot pick).

Verification
REQ-033 m0 read addr 32'h0300_0000, target s_ready 2 cycles after s_valid with rdata 32'h1234_5678 -> m0_ready single pulse, m0_rdata=32'h1234_5678, grant 01 then 00.
REQ-034 m0,m1 both valid from reset (writes 32'hA, 32'hB) -> m0 served first, m1 second; then both again -> m0 served first again (pointer alternates).
REQ-035 Target never asserts s_ready, TIMEOUT_CYCLES=4 -> s_valid 4 cycles, m_ready + timeout_err pulse together, rdata=32'hFFFF_FFFF.
REQ-036 s_ready in exactly the 4th REQ cycle (TIMEOUT_CYCLES=4) -> normal completion, timeout_err=0.
REQ-037 reset asserted during REQ of m1 -> next cycle s_valid=0, grant=00, no m1_ready; m1 reissue completes normally.
REQ-038 m0 wstrb=4'b0101 data 32'hCAFE_F00D -> s_wstrb/s_wdata match for whole REQ; m1_ready never pulses.
